// File: rtl/baluga_isa_pkg.sv
// Shared definitions for the 9-bit BaLuGa core: widths, opcodes and fetch FSM states.
package baluga_isa_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned ADDR_W  = 8;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_LD  = 4'b0001;
  localparam logic [3:0] OP_ST  = 4'b0010;
  localparam logic [3:0] OP_STT = 4'b0101;
  localparam logic [3:0] OP_STF = 4'b0110;
  localparam logic [3:0] OP_INC = 4'b0111;
  localparam logic [3:0] OP_SWP = 4'b1001;
  localparam logic [3:0] OP_SLW = 4'b1010;
  localparam logic [3:0] OP_SHG = 4'b1011;
  localparam logic [3:0] OP_BE  = 4'b1100;
  localparam logic [3:0] OP_BL  = 4'b1101;
  localparam logic [3:0] OP_JMP = 4'b1110;

  typedef enum logic [0:0] {RUN, HALT} fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Sequential PC increment and redirect target selection.
// With FETCH_REL_BRANCH_EN defined, redirects may be relative to redirect_pc.
module fetch_next_pc
  import baluga_isa_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_REL_BRANCH_EN
  input  logic              redirect_rel,
  input  logic [ADDR_W-1:0] redirect_off,
`endif
  output logic [ADDR_W-1:0] pc_inc,
  output logic [ADDR_W-1:0] target
);

  assign pc_inc = pc + ADDR_W'(1);

`ifdef FETCH_REL_BRANCH_EN
  // Offset already spans the full address width, so the add wraps mod 256.
  assign target = redirect_rel ? (redirect_pc + redirect_off) : redirect_pc;
`else
  assign target = redirect_pc;
`endif

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the ROM address, registers one instruction and offers it to decode.
// Optional relative redirects are enabled with FETCH_REL_BRANCH_EN.
module instruction_fetch
  import baluga_isa_pkg::*;
#(
  parameter int unsigned PROG_LEN = 42,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
`ifdef FETCH_REL_BRANCH_EN
  input  logic               redirect_rel,
  input  logic [ADDR_W-1:0]  redirect_off,
`endif
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  // A full 256-word program never halts; the PC simply wraps.
  localparam logic             HALT_EN  = (PROG_LEN < 256);
  localparam logic [ADDR_W:0]  PROG_END = (ADDR_W + 1)'(PROG_LEN);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  target;
  logic               slot_free;
  logic               at_end;
  logic               target_in_prog;

  fetch_next_pc u_next_pc (
    .pc          (pc_q),
    .redirect_pc (redirect_pc),
`ifdef FETCH_REL_BRANCH_EN
    .redirect_rel(redirect_rel),
    .redirect_off(redirect_off),
`endif
    .pc_inc      (pc_inc),
    .target      (target)
  );

  assign slot_free      = !valid_q || if_ready;
  assign at_end         = HALT_EN && ({1'b0, pc_q} == PROG_END);
  assign target_in_prog = !HALT_EN || ({1'b0, target} < PROG_END);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    cnt_d   = cnt_q;

    if (valid_q && if_ready && !redirect_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (redirect_valid) begin
      // Flush the held word; the first fetch from target happens next cycle.
      valid_d = 1'b0;
      pc_d    = target;
      state_d = target_in_prog ? RUN : HALT;
    end else begin
      unique case (state_q)
        RUN: begin
          if (slot_free) begin
            if (at_end) begin
              state_d = HALT;
              valid_d = 1'b0;
            end else begin
              instr_d = rom_data;
              ifpc_d  = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_inc;
            end
          end
        end
        HALT: begin
          if (if_ready) valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr    = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_instruction_fetch;

  localparam int unsigned PROG_LEN = 42;
  localparam int unsigned CNT_W    = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0]       rom_addr;
  logic [8:0]       rom_data;
  logic             if_valid;
  logic             if_ready;
  logic [8:0]       if_instr;
  logic [7:0]       if_pc;
  logic             redirect_valid;
  logic [7:0]       redirect_pc;
  logic             redirect_rel;
  logic [7:0]       redirect_off;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  logic [8:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic       m_valid;
  logic [8:0] m_instr;
  logic [7:0] m_ifpc;
  logic       m_halted;
  int         m_cnt;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  instruction_fetch #(
    .PROG_LEN(PROG_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
`ifdef FETCH_REL_BRANCH_EN
    .redirect_rel  (redirect_rel),
    .redirect_off  (redirect_off),
`endif
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_valid = 0; m_instr = 0; m_ifpc = 0; m_halted = 0; m_cnt = 0;
  endtask

  // One clock of the stage described as transactions: redirect, accept, then refill.
  task automatic model_step(input logic rdy, input logic rv, input logic [7:0] rpc,
                            input logic rrel, input logic [7:0] roff);
    int tgt;
    if (rv) begin
      tgt = rrel ? ((int'(rpc) + int'($signed(roff))) & 255) : int'(rpc);
      m_valid  = 0;
      m_pc     = 8'(tgt);
      m_halted = (PROG_LEN < 256) && (tgt >= PROG_LEN);
    end else begin
      if (m_valid && rdy && m_cnt < 65535) m_cnt++;
      if (!m_valid || rdy) begin
        if (!m_halted && (PROG_LEN == 256 || int'(m_pc) != PROG_LEN)) begin
          m_instr = rom[m_pc];
          m_ifpc  = m_pc;
          m_valid = 1;
          m_pc    = m_pc + 8'd1;
        end else begin
          m_valid  = 0;
          m_halted = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".if_valid"}, 32'(if_valid), 32'(m_valid));
    chk({tag, ".if_pc"}, 32'(if_pc), 32'(m_ifpc));
    chk({tag, ".if_instr"}, 32'(if_instr), 32'(m_instr));
    chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(m_pc));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halted));
    chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(m_cnt));
  endtask

  // Drive inputs just after an edge, advance one clock, sample 1 time unit later.
  task automatic cyc(input string tag, input logic rdy, input logic rv, input logic [7:0] rpc,
                     input logic rrel, input logic [7:0] roff);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    redirect_rel   = rrel;
    redirect_off   = roff;
    model_step(rdy, rv, rpc, rrel, roff);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic run_until_halt(input string tag);
    for (int i = 0; i < 100 && !m_halted; i++) cyc(tag, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk({tag, ".halt_reached"}, 32'(halted), 32'd1);
  endtask

  initial begin
    int cnt_before;
    logic rel;
    for (int i = 0; i < 256; i++) rom[i] = 9'($urandom);
    rom[5]  = 9'b1011_1_1111;
    rom[22] = 9'b1010_1_1011;

    reset_n = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    redirect_rel = 1'b0; redirect_off = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // 1: straight-line program to the end
    for (int i = 0; i < 42; i++) begin
      cyc("seq", 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
      chk("seq.pc_const", 32'(if_pc), i);
    end
    cyc("seq_end", 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("seq_end.halted", 32'(halted), 32'd1);
    chk("seq_end.valid", 32'(if_valid), 32'd0);
    chk("seq_end.count", 32'(fetch_count), 32'd42);

    // 2: stall at if_pc=5
    cyc("redir0", 1'b1, 1'b1, 8'd0, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) cyc("to5", 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("to5.pc", 32'(if_pc), 32'd5);
    for (int i = 0; i < 3; i++) begin
      cyc("stall", 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
      chk("stall.instr", 32'(if_instr), 32'(9'b1011_1_1111));
      chk("stall.pc", 32'(if_pc), 32'd5);
      chk("stall.rom_addr", 32'(rom_addr), 32'd6);
    end
    cyc("resume", 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("resume.pc", 32'(if_pc), 32'd6);

    // 3: redirect overrides a same-cycle handshake
    for (int i = 0; i < 24; i++) cyc("to30", 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("to30.pc", 32'(if_pc), 32'd30);
    cnt_before = int'(fetch_count);
    cyc("br22", 1'b1, 1'b1, 8'd22, 1'b0, 8'd0);
    chk("br22.valid", 32'(if_valid), 32'd0);
    chk("br22.count", 32'(fetch_count), 32'(cnt_before));
    cyc("br22_tgt", 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("br22_tgt.pc", 32'(if_pc), 32'd22);
    chk("br22_tgt.instr", 32'(if_instr), 32'(9'b1010_1_1011));

    // 4: leave HALT by redirect, then redirect past the end
    run_until_halt("halt_a");
    cyc("br36", 1'b1, 1'b1, 8'd36, 1'b0, 8'd0);
    chk("br36.halted", 32'(halted), 32'd0);
    run_until_halt("halt_b");
    chk("halt_b.last_pc", 32'(if_pc), 32'd41);
    cyc("br50", 1'b1, 1'b1, 8'd50, 1'b0, 8'd0);
    chk("br50.halted", 32'(halted), 32'd1);
    cyc("br50_idle", 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("br50_idle.valid", 32'(if_valid), 32'd0);

    // 5: asynchronous reset mid-stream
    cyc("redir0b", 1'b1, 1'b1, 8'd0, 1'b0, 8'd0);
    for (int i = 0; i < 13; i++) cyc("to12", 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("to12.pc", 32'(if_pc), 32'd12);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc("post_rst", 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("post_rst.pc", 32'(if_pc), 32'd0);

`ifdef FETCH_REL_BRANCH_EN
    // 6: relative redirects, including address wrap
    cyc("rel_m9", 1'b1, 1'b1, 8'd15, 1'b1, 8'hF7);
    cyc("rel_m9_tgt", 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("rel_m9.pc", 32'(if_pc), 32'd6);
    cyc("rel_wrap", 1'b1, 1'b1, 8'd250, 1'b1, 8'd10);
    cyc("rel_wrap_tgt", 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("rel_wrap.pc", 32'(if_pc), 32'd4);
`endif

    // Random traffic: backpressure, redirects in and beyond the program
    for (int i = 0; i < 400; i++) begin
`ifdef FETCH_REL_BRANCH_EN
      rel = 1'($urandom_range(0, 1));
`else
      rel = 1'b0;
`endif
      cyc("rand", ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
          8'($urandom_range(0, 60)), rel, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage between the program counter and decode for the 9-bit BaLuGa core.
- Drives the address of the combinational instruction ROM (8-bit address in, 9-bit instruction out) and registers the returned word into a one-entry instruction register.
- Offers that word to decode through a valid/ready handshake.
- Accepts redirects (branch/jump) from execute and stops fetching at the program end.

Parameters:
- PROG_LEN, 42, number of valid ROM words; fetch halts when PC == PROG_LEN. A value of 256 disables the halt and lets the PC wrap.
- CNT_W, 16, width of the saturating fetch-handshake counter.

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rom_addr  out  8  ROM address; always equals the internal PC
- rom_data  in  9  ROM instruction for rom_addr, combinational
- if_valid  out  1  if_instr/if_pc hold a valid instruction
- if_ready  in  1  decode accepts this cycle
- if_instr  out  9  registered instruction
- if_pc  out  8  address if_instr was fetched from
- redirect_valid  in  1  execute requests a PC change (be/bl taken, jmp)
- redirect_pc  in  8  redirect target (absolute)
- redirect_rel  in  1  [FETCH_REL_BRANCH_EN only] target is relative
- redirect_off  in  8  [FETCH_REL_BRANCH_EN only] signed two's-complement offset
- halted  out  1  fetch stopped at program end
- fetch_count  out  CNT_W  number of accepted handshakes, saturating

Behaviour:
- Reset (asynchronous, while reset_n=0): pc=0, if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_count=0, state=RUN.
- States: RUN, HALT.
- Slot free: slot_free = !if_valid || if_ready.
- Fetch in RUN, when slot_free && !redirect_valid && pc != PROG_LEN:
  - if_instr<=rom_data, if_pc<=pc, if_valid<=1, pc<=pc+1 (mod 256).
  - Latency: the word at address A appears on if_instr one cycle after rom_addr==A.
  - Full throughput: one instruction per cycle while if_ready=1.
- Stall: if_valid && !if_ready holds if_instr, if_pc and pc unchanged. rom_addr stays stable.
- Halt: in RUN with slot_free && pc==PROG_LEN (and PROG_LEN<256), go to HALT and set halted<=1. If if_ready=1 that cycle, if_valid<=0. A pending instruction is never dropped; it is consumed first because slot_free is required.
- HALT state: no fetch. halted stays 1. if_valid clears once the held word is accepted.
- Redirect, highest priority, in any state:
  - if_valid<=0, flushing the registered word even if if_ready=1. That word does not count.
  - pc<=target.
  - If target < PROG_LEN (or PROG_LEN==256): state<=RUN, halted<=0. Otherwise: state<=HALT, halted<=1.
  - No fetch occurs in the redirect cycle. The first fetch from the target happens the next cycle, giving a one-bubble branch penalty.
- Redirect and handshake in the same cycle: the redirect wins. if_valid becomes 0 and fetch_count is not incremented.
- fetch_count increments on if_valid && if_ready && !redirect_valid, and saturates at all-ones.
- reset_n asserted mid-operation clears everything immediately, with no clock edge needed. The first fetch occurs on the first rising edge after reset_n rises.

Optional Feature:
- Macro: FETCH_REL_BRANCH_EN.
- Defined:
  - Ports redirect_rel and redirect_off exist.
  - If redirect_rel=1: target = redirect_pc + sign-extended redirect_off, 8-bit wrap. redirect_pc carries the branch instruction's PC.
  - If redirect_rel=0: target = redirect_pc.
- Undefined: those ports are absent and target = redirect_pc always.

Decomposition:
- Shared package baluga_isa_pkg: INSTR_W=9, ADDR_W=8, opcode constants (ADD=0000, LD=0001, ST=0010, STT=0101, STF=0110, INC=0111, SWP=1001, SLW=1010, SHG=1011, BE=1100, BL=1101, JMP=1110), fetch state enum {RUN, HALT}.
- One sub-module, fetch_next_pc: combinational next-PC/target mux including the optional relative adder. Everything else stays in instruction_fetch.

Test Plan:
1. Release reset with if_ready=1 held and ROM = prog3 → if_pc sequence 0,1,2,…,41 on consecutive cycles. Then halted=1, if_valid=0, fetch_count=42.
2. Drop if_ready for 3 cycles while if_pc=5 → if_instr=9'b1011_1_1111 and if_pc=5 hold. rom_addr=6 is stable. Resume → next if_pc=6.
3. redirect_valid, redirect_pc=22, asserted while if_pc=30 valid and if_ready=1 → next cycle if_valid=0, count not incremented. Following cycle if_pc=22, if_instr=9'b1010_1_1011.
4. In HALT, redirect_pc=36 → halted=0; if_pc 36..41 fetched, then halted=1 again. A redirect to 50 → halted=1 with no fetch.
5. Assert reset_n=0 asynchronously mid-stream with if_pc=12 valid → if_valid, halted, pc and fetch_count are 0 before the next clk edge.
6. [FETCH_REL_BRANCH_EN] redirect_rel=1, redirect_pc=15, redirect_off=8'hF7 (−9) → next fetched if_pc=6. With redirect_pc=250, off=+10 and PROG_LEN=256 → if_pc=4 (wrap).
